// File: rtl/class_arbiter_if.sv
// class_arbiter_if: FIFO read side and downstream output side of the class arbiter
interface class_arbiter_if #(
    parameter int DATA_SIZE = 10,
    parameter int MAIN_SIZE = 8
);
    logic [DATA_SIZE-1:0] fifo0_data;
    logic [DATA_SIZE-1:0] fifo1_data;
    logic                 fifo0_empty;
    logic                 fifo1_empty;
    logic                 down_pause;
    logic                 pop0;
    logic                 pop1;
    logic [DATA_SIZE-1:0] data_out;
    logic                 valid_out;
    logic                 class_out;
    logic [MAIN_SIZE-1:0] cnt0;
    logic [MAIN_SIZE-1:0] cnt1;

    modport master (
        input  fifo0_data, fifo1_data, fifo0_empty, fifo1_empty, down_pause,
        output pop0, pop1, data_out, valid_out, class_out, cnt0, cnt1
    );

    modport slave (
        output fifo0_data, fifo1_data, fifo0_empty, fifo1_empty, down_pause,
        input  pop0, pop1, data_out, valid_out, class_out, cnt0, cnt1
    );
endinterface

// File: rtl/class_arbiter.sv
// class_arbiter: weighted round-robin drain of two class FIFOs into one tagged stream
module class_arbiter #(
    parameter int DATA_SIZE = 10,
    parameter int MAIN_SIZE = 8,
    parameter int WEIGHT0   = 4,
    parameter int WEIGHT1   = 1
) (
    input logic            clk,
    input logic            reset,
    class_arbiter_if.master bus
);
    localparam int MAXW = (WEIGHT0 > WEIGHT1) ? WEIGHT0 : WEIGHT1;
    localparam int BW   = $clog2(MAXW + 1);
    localparam logic [BW-1:0] LAST0 = BW'(WEIGHT0 - 1);
    localparam logic [BW-1:0] LAST1 = BW'(WEIGHT1 - 1);

    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

    state_t               state, state_next;
    logic [BW-1:0]        burst, burst_next;
    logic                 pend0, pend1;
    logic [DATA_SIZE-1:0] word;

    // next-state, burst and pop strobes; a pause freezes everything
    always_comb begin
        state_next = state;
        burst_next = burst;
        bus.pop0   = 1'b0;
        bus.pop1   = 1'b0;
        if (!bus.down_pause) begin
            case (state)
                IDLE:   state_next = !bus.fifo0_empty ? SERVE0 : (!bus.fifo1_empty ? SERVE1 : IDLE);
                SERVE0: begin
                    if (bus.fifo0_empty) begin
                        burst_next = '0;
                        state_next = bus.fifo1_empty ? IDLE : SERVE1;
                    end else begin
                        bus.pop0   = 1'b1;
                        burst_next = (burst == LAST0) ? '0 : burst + 1'b1;
                        state_next = (burst == LAST0 && !bus.fifo1_empty) ? SERVE1 : SERVE0;
                    end
                end
                SERVE1: begin
                    if (bus.fifo1_empty) begin
                        burst_next = '0;
                        state_next = bus.fifo0_empty ? IDLE : SERVE0;
                    end else begin
                        bus.pop1   = 1'b1;
                        burst_next = (burst == LAST1) ? '0 : burst + 1'b1;
                        state_next = (burst == LAST1 && !bus.fifo0_empty) ? SERVE0 : SERVE1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // arbitration state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            burst <= '0;
        end else begin
            state <= state_next;
            burst <= burst_next;
        end
    end

    // select the FIFO whose read data arrives this cycle
    always_comb word = pend1 ? bus.fifo1_data : bus.fifo0_data;

    // pop -> pending -> captured output, plus per-class forwarded-word counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend0         <= 1'b0;
            pend1         <= 1'b0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.class_out <= 1'b0;
            bus.cnt0      <= '0;
            bus.cnt1      <= '0;
        end else begin
            pend0         <= bus.pop0;
            pend1         <= bus.pop1;
            bus.valid_out <= pend0 | pend1;
            if (pend0 | pend1) begin
                bus.data_out  <= word;
                bus.class_out <= pend1;
            end
            if (pend0) bus.cnt0 <= bus.cnt0 + MAIN_SIZE'(1);
            if (pend1) bus.cnt1 <= bus.cnt1 + MAIN_SIZE'(1);
        end
    end
endmodule

// File: tb/tb_class_arbiter.sv
// tb_class_arbiter: directed scenario table plus hand sequences for pause, reset and counter wrap
module tb_class_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   e0 = 0;
    int   e1 = 0;
    int   w0 = 0, r0 = 0, w1 = 0, r1 = 0;
    logic [9:0]  mem0 [0:1023];
    logic [9:0]  mem1 [0:1023];
    logic [9:0]  exp0 [$];
    logic [9:0]  exp1 [$];
    logic [10:0] out_q [$];

    typedef struct {
        int         n0;
        int         n1;
        logic [15:0] cls;
    } vec_t;
    vec_t tbl [6];

    class_arbiter_if #(.DATA_SIZE(10), .MAIN_SIZE(8)) bus ();

    class_arbiter #(.DATA_SIZE(10), .MAIN_SIZE(8), .WEIGHT0(4), .WEIGHT1(1)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.fifo0_empty = (r0 == w0);
    assign bus.fifo1_empty = (r1 == w1);

    always @(posedge clk) begin
        if (bus.pop0) begin
            bus.fifo0_data <= mem0[r0];
            r0 <= r0 + 1;
        end
        if (bus.pop1) begin
            bus.fifo1_data <= mem1[r1];
            r1 <= r1 + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("pop_exclusive", 32'(bus.pop0 & bus.pop1), 0);
        if (bus.valid_out) out_q.push_back({bus.class_out, bus.data_out});
    end

    task automatic push0(input logic [9:0] v);
        mem0[w0] = v;
        w0 = w0 + 1;
        exp0.push_back(v);
    endtask

    task automatic push1(input logic [9:0] v);
        mem1[w1] = v;
        w1 = w1 + 1;
        exp1.push_back(v);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.pop0, bus.pop1, bus.valid_out, bus.class_out, bus.data_out, bus.cnt0, bus.cnt1});
    endfunction

    task automatic wait_drain();
        int k = 0;
        while (!(r0 == w0 && r1 == w1) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_bound", 32'(k >= 3000), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_run(input logic [15:0] cls, input int n);
        logic [9:0] want;
        chk("out_count", out_q.size(), n);
        for (int i = 0; i < n && i < out_q.size(); i++) begin
            want = '1;
            if (cls[i] && exp1.size() > 0) want = exp1.pop_front();
            else if (!cls[i] && exp0.size() > 0) want = exp0.pop_front();
            chk("out_class", 32'(out_q[i][10]), 32'(cls[i]));
            chk("out_data", 32'(out_q[i][9:0]), 32'(want));
        end
        for (int i = 0; i < n; i++) begin
            if (cls[i]) e1++;
            else e0++;
        end
        chk("cnt0", 32'(bus.cnt0), 32'(e0 % 256));
        chk("cnt1", 32'(bus.cnt1), 32'(e1 % 256));
        exp0.delete();
        exp1.delete();
        out_q.delete();
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_zero", all_outs(), 0);
        reset = 1'b1;
        e0 = 0;
        e1 = 0;
        out_q.delete();
    endtask

    initial begin
        int k;
        int c;
        int s;
        int g;
        g = 0;
        bus.down_pause = 1'b0;
        tbl[0] = '{n0: 3, n1: 0, cls: 16'h0000};
        tbl[1] = '{n0: 6, n1: 2, cls: 16'h0090};
        tbl[2] = '{n0: 0, n1: 3, cls: 16'h0007};
        tbl[3] = '{n0: 2, n1: 2, cls: 16'h000C};
        tbl[4] = '{n0: 9, n1: 3, cls: 16'h0A10};
        tbl[5] = '{n0: 1, n1: 1, cls: 16'h0002};

        // reset held with both FIFOs non-empty
        push0(10'h011);
        push1(10'h322);
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold_zero", all_outs(), 0);
        end
        reset = 1'b1;
        wait_drain();
        check_run(16'h0002, 2);

        // FIFO0 only: three words back-to-back, latency 2
        rst_pulse();
        push0(10'h0FF);
        push0(10'h0EE);
        push0(10'h0BB);
        k = 0;
        while (!bus.pop0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        c = cyc;
        while (!bus.valid_out && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", cyc - c, 2);
        chk("seq_d0", 32'({bus.valid_out, bus.data_out}), 32'({1'b1, 10'h0FF}));
        @(negedge clk);
        chk("seq_d1", 32'({bus.valid_out, bus.data_out}), 32'({1'b1, 10'h0EE}));
        @(negedge clk);
        chk("seq_d2", 32'({bus.valid_out, bus.data_out}), 32'({1'b1, 10'h0BB}));
        @(negedge clk);
        chk("seq_end_valid", 32'(bus.valid_out), 0);
        chk("seq_cnt0", 32'(bus.cnt0), 3);
        repeat (2) @(negedge clk);
        chk("seq_idle_pops", 32'({bus.pop0, bus.pop1}), 0);
        check_run(16'h0000, 3);

        // scenario table
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int j = 0; j < tbl[i].n0; j++) begin
                push0(10'(10'h100 + g));
                g++;
            end
            for (int j = 0; j < tbl[i].n1; j++) begin
                push1(10'(10'h200 + g));
                g++;
            end
            wait_drain();
            check_run(tbl[i].cls, tbl[i].n0 + tbl[i].n1);
        end

        // pause while SERVE1 streams
        @(negedge clk);
        for (int j = 1; j <= 5; j++) push1(10'(10'h300 + j));
        k = 0;
        while (!bus.pop1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("pause_pop_seen", 32'(bus.pop1), 1);
        @(negedge clk);
        bus.down_pause = 1'b1;
        #1;
        chk("pause_pop_stop", 32'(bus.pop1), 0);
        s = out_q.size();
        repeat (4) begin
            @(negedge clk);
            chk("pause_no_pop", 32'({bus.pop0, bus.pop1}), 0);
        end
        chk("pause_drain_le2", 32'(out_q.size() - s <= 2), 1);
        bus.down_pause = 1'b0;
        #1;
        chk("pause_resume", 32'(bus.pop1), 1);
        wait_drain();
        check_run(16'h001F, 5);

        // reset while a pop is pending
        @(negedge clk);
        push0(10'h1A1);
        push0(10'h1B2);
        push0(10'h1C3);
        @(negedge clk);
        chk("pend_pop", 32'(bus.pop0), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("pend_rst_valid", 32'(bus.valid_out), 0);
        @(negedge clk);
        chk("pend_rst_zero", all_outs(), 0);
        @(negedge clk);
        chk("pend_rst_zero2", all_outs(), 0);
        push1(10'h3E4);
        void'(exp0.pop_front());
        e0 = 0;
        e1 = 0;
        out_q.delete();
        reset = 1'b1;
        wait_drain();
        check_run(16'h0004, 3);

        // counter wrap on class 1
        rst_pulse();
        for (int j = 0; j < 257; j++) push1(10'(j));
        wait_drain();
        chk("wrap_count", out_q.size(), 257);
        chk("wrap_cnt1", 32'(bus.cnt1), 1);
        chk("wrap_cnt0", 32'(bus.cnt0), 0);
        if (out_q.size() == 257) chk("wrap_last", 32'(out_q[256]), 32'({1'b1, 10'd256}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
